captura_jogada: RTL and testbench

CAPTURA_JOGADA -- requirements
Module: captura_jogada

---
 rtl/captura_jogada.sv | 178 +++++++++++++++++
 tb/tb_captura_jogada.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/captura_jogada.sv
// Move capture front-end: synchronises and debounces the row/column/confirm buttons and emits one encoded move per confirm press.
// Optional auto-confirm on long hold is enabled by defining CAPTURA_JOGADA_AUTO_CONFIRMA_EN.
module captura_jogada #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned AUTO_CYCLES     = 100000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] botoesLinha,
  input  logic [7:0] botoesColuna,
  input  logic       confirmar,
  output logic [2:0] jogadaFileira,
  output logic [2:0] jogadaColuna,
  output logic       temJogada,
  output logic       db_invalida,
  output logic [2:0] db_estado
);

  localparam int unsigned NIN  = 17;
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ESPERA      = 3'd0,
    SELECIONADO = 3'd1,
    EMITE       = 3'd2,
    SOLTA       = 3'd3,
    ERRO        = 3'd4
  } state_t;

  if (DEBOUNCE_CYCLES < 1 || AUTO_CYCLES < 1) begin : g_bad_params
    $error("captura_jogada: DEBOUNCE_CYCLES and AUTO_CYCLES must be at least 1");
  end

  // Bit layout of the 17 inputs: [7:0] rows, [15:8] columns, [16] confirm.
  logic [NIN-1:0]  raw;
  logic [NIN-1:0]  sync1_q, sync2_q;
  logic [NIN-1:0]  deb_q, deb_d;
  logic [DB_W-1:0] cnt_q [NIN];
  logic [DB_W-1:0] cnt_d [NIN];
  logic            conf_prev_q, conf_prev_d;
  state_t          state_q, state_d;
  logic [2:0]      fil_q, fil_d;
  logic [2:0]      col_q, col_d;

  logic [7:0] row_deb, col_deb;
  logic       sel_valid;
  logic       conf_edge;
  logic       all_released;
  logic       auto_fire;

  assign raw = {confirmar, botoesColuna, botoesLinha};

  function automatic logic [2:0] enc8(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // A debounced bit flips only once its synchronised input has disagreed
  // for DEBOUNCE_CYCLES consecutive cycles; agreement restarts the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NIN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign row_deb      = deb_q[7:0];
  assign col_deb      = deb_q[15:8];
  assign sel_valid    = ($countones(row_deb) == 1) && ($countones(col_deb) == 1);
  assign conf_edge    = deb_q[16] & ~conf_prev_q;
  assign conf_prev_d  = deb_q[16];
  assign all_released = (deb_q == '0);

`ifdef CAPTURA_JOGADA_AUTO_CONFIRMA_EN
  localparam int unsigned HOLD_W = $clog2(AUTO_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(AUTO_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [15:0]       bus_prev_q;
  logic              bus_changed;

  assign bus_changed = (deb_q[15:0] != bus_prev_q);

  // Counter value equals cycles already spent in SELECIONADO, so the
  // strobe lands exactly AUTO_CYCLES cycles after entry.
  always_comb begin
    hold_d = hold_q;
    if (bus_changed || (state_d == SELECIONADO && state_q != SELECIONADO)) begin
      hold_d = '0;
    end else if (state_q == SELECIONADO && hold_q != HOLD_LAST) begin
      hold_d = hold_q + 1'b1;
    end
  end

  assign auto_fire = (state_q == SELECIONADO) && !bus_changed && (hold_q == HOLD_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_q     <= '0;
      bus_prev_q <= '0;
    end else begin
      hold_q     <= hold_d;
      bus_prev_q <= deb_q[15:0];
    end
  end
`else
  assign auto_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    fil_d   = fil_q;
    col_d   = col_q;
    case (state_q)
      ESPERA: begin
        // A confirm edge arriving together with a valid selection is dropped.
        if (sel_valid) state_d = SELECIONADO;
        else if (conf_edge) state_d = ERRO;
      end
      SELECIONADO: begin
        if (!sel_valid) begin
          state_d = ESPERA;
        end else if (conf_edge || auto_fire) begin
          fil_d   = enc8(row_deb);
          col_d   = enc8(col_deb);
          state_d = EMITE;
        end
      end
      EMITE: state_d = SOLTA;
      SOLTA, ERRO: begin
        if (all_released) state_d = ESPERA;
      end
      default: state_d = ESPERA;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      conf_prev_q <= 1'b0;
      state_q     <= ESPERA;
      fil_q       <= '0;
      col_q       <= '0;
      for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      conf_prev_q <= conf_prev_d;
      state_q     <= state_d;
      fil_q       <= fil_d;
      col_q       <= col_d;
      for (int i = 0; i < NIN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Strobe decoded from the state register so reset kills it immediately.
  assign temJogada     = (state_q == EMITE);
  assign db_invalida   = (state_q == ERRO);
  assign db_estado     = state_q;
  assign jogadaFileira = fil_q;
  assign jogadaColuna  = col_q;

endmodule

// File: tb/tb_captura_jogada.sv
// Bench for captura_jogada: table-driven selections plus hand sequences for glitch, re-press, reset-in-EMITE and auto-confirm.
module tb_captura_jogada;

  localparam int DB = 4;
  localparam int AC = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] botoesLinha = '0;
  logic [7:0] botoesColuna = '0;
  logic       confirmar = 1'b0;
  logic [2:0] jogadaFileira, jogadaColuna;
  logic       temJogada, db_invalida;
  logic [2:0] db_estado;

  captura_jogada #(.DEBOUNCE_CYCLES(DB), .AUTO_CYCLES(AC)) dut (
    .clock(clock), .reset(reset),
    .botoesLinha(botoesLinha), .botoesColuna(botoesColuna), .confirmar(confirmar),
    .jogadaFileira(jogadaFileira), .jogadaColuna(jogadaColuna),
    .temJogada(temJogada), .db_invalida(db_invalida), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [5:0]  exp_q[$];
  int          pulse_total = 0;
  int          trans_total = 0;
  logic [31:0] trans_log = '0;
  logic [2:0]  last_state = '0;
  logic        prev_tem = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Monitor: scoreboard for strobes and a log of state transitions (state+1 per nibble).
  always @(negedge clock) begin
    logic [5:0] e;
    if (temJogada === 1'b1) begin
      pulse_total++;
      chk("no_back_to_back", 32'(prev_tem), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_strobe: got fil=%0d col=%0d, required no strobe",
                 jogadaFileira, jogadaColuna);
      end else begin
        e = exp_q.pop_front();
        chk("move_fil_col", 32'({jogadaFileira, jogadaColuna}), 32'(e));
      end
    end
    prev_tem = temJogada;
    if (db_estado !== last_state) begin
      trans_total++;
      trans_log  = {trans_log[27:0], 4'(db_estado) + 4'd1};
      last_state = db_estado;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [7:0] r, input logic [7:0] c, input logic cf);
    botoesLinha  = r;
    botoesColuna = c;
    confirmar    = cf;
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clock);
      #1;
      if (db_estado == target) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      $display("FAIL wait_state: got state %0d after %0d cycles, required %0d", db_estado, budget, target);
    end
  endtask

  typedef struct {
    logic [7:0]  row;
    logic [7:0]  col;
    logic        pulse;
    logic [2:0]  e_fil;
    logic [2:0]  e_col;
    logic [15:0] log;
    int          ntrans;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input int idx);
    int p0, t0;
    logic [31:0] mask;
    p0 = pulse_total;
    t0 = trans_total;
    drive(v.row, v.col, 1'b0);
    cyc(12);
    if (v.pulse) exp_q.push_back({v.e_fil, v.e_col});
    drive(v.row, v.col, 1'b1);
    cyc(10);
    drive(8'h00, 8'h00, 1'b0);
    cyc(15);
    mask = (32'd1 << (4 * v.ntrans)) - 32'd1;
    chk($sformatf("vec%0d_pulses", idx), 32'(pulse_total - p0), 32'(v.pulse));
    chk($sformatf("vec%0d_ntrans", idx), 32'(trans_total - t0), 32'(v.ntrans));
    chk($sformatf("vec%0d_state_seq", idx), trans_log & mask, 32'(v.log));
  endtask

  initial begin
    int p0, t0, n;
    bit found;

    // Valid: states 1,2,3,0 -> nibbles 2,3,4,1. Invalid: 4,0 -> 5,1.
    vecs[0] = '{8'h01, 8'h02, 1'b1, 3'd0, 3'd1, 16'h2341, 4};
    vecs[1] = '{8'h80, 8'h40, 1'b1, 3'd7, 3'd6, 16'h2341, 4};
    vecs[2] = '{8'h10, 8'h08, 1'b1, 3'd4, 3'd3, 16'h2341, 4};
    vecs[3] = '{8'h03, 8'h01, 1'b0, 3'd0, 3'd0, 16'h0051, 2};
    vecs[4] = '{8'h00, 8'h04, 1'b0, 3'd0, 3'd0, 16'h0051, 2};
    vecs[5] = '{8'h20, 8'h20, 1'b1, 3'd5, 3'd5, 16'h2341, 4};

    cyc(3);
    reset = 1'b0;
    cyc(2);
    chk("rst_temJogada", 32'(temJogada), 32'd0);
    chk("rst_fileira", 32'(jogadaFileira), 32'd0);
    chk("rst_coluna", 32'(jogadaColuna), 32'd0);
    chk("rst_invalida", 32'(db_invalida), 32'd0);
    chk("rst_estado", 32'(db_estado), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Error state flag while an invalid selection is confirmed.
    drive(8'h03, 8'h01, 1'b1);
    wait_state(3'd4, 30, found);
    chk("erro_invalida", 32'(db_invalida), 32'd1);
    drive(8'h00, 8'h00, 1'b0);
    cyc(15);
    chk("erro_release_estado", 32'(db_estado), 32'd0);
    chk("erro_release_invalida", 32'(db_invalida), 32'd0);

    // Three-cycle glitch is filtered out.
    p0 = pulse_total;
    t0 = trans_total;
    drive(8'h01, 8'h00, 1'b0);
    cyc(3);
    drive(8'h00, 8'h00, 1'b0);
    cyc(15);
    chk("glitch_ntrans", 32'(trans_total - t0), 32'd0);
    chk("glitch_pulses", 32'(pulse_total - p0), 32'd0);

    // Re-pressing confirm with buttons still held yields nothing.
    p0 = pulse_total;
    drive(8'h01, 8'h02, 1'b0);
    cyc(12);
    exp_q.push_back({3'd0, 3'd1});
    drive(8'h01, 8'h02, 1'b1);
    cyc(10);
    drive(8'h01, 8'h02, 1'b0);
    cyc(10);
    chk("repress_solta", 32'(db_estado), 32'd3);
    drive(8'h01, 8'h02, 1'b1);
    cyc(10);
    drive(8'h01, 8'h02, 1'b0);
    cyc(10);
    chk("repress_pulses", 32'(pulse_total - p0), 32'd1);
    drive(8'h00, 8'h00, 1'b0);
    cyc(15);
    chk("repress_release", 32'(db_estado), 32'd0);
    drive(8'h04, 8'h01, 1'b0);
    cyc(12);
    exp_q.push_back({3'd2, 3'd0});
    drive(8'h04, 8'h01, 1'b1);
    cyc(10);
    drive(8'h00, 8'h00, 1'b0);
    cyc(15);
    chk("reselect_pulses", 32'(pulse_total - p0), 32'd2);

    // Reset landing in EMITE kills the strobe; held buttons are then re-debounced.
    p0 = pulse_total;
    drive(8'h02, 8'h01, 1'b0);
    cyc(12);
    drive(8'h02, 8'h01, 1'b1);
    wait_state(3'd2, 30, found);
    reset = 1'b1;
    #1;
    chk("rst_emite_tem", 32'(temJogada), 32'd0);
    chk("rst_emite_estado", 32'(db_estado), 32'd0);
    chk("rst_emite_fileira", 32'(jogadaFileira), 32'd0);
    cyc(3);
    reset = 1'b0;
    cyc(12);
    chk("post_rst_selecionado", 32'(db_estado), 32'd1);
    chk("post_rst_pulses", 32'(pulse_total - p0), 32'd0);
    drive(8'h00, 8'h00, 1'b0);
    cyc(15);
    chk("post_rst_release", 32'(db_estado), 32'd0);

    // Long hold with no confirm.
    p0 = pulse_total;
    drive(8'h80, 8'h40, 1'b0);
    wait_state(3'd1, 30, found);
`ifdef CAPTURA_JOGADA_AUTO_CONFIRMA_EN
    exp_q.push_back({3'd7, 3'd6});
    n = 0;
    for (int i = 0; i < 40 && temJogada !== 1'b1; i++) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("auto_latency", 32'(n), 32'(AC));
    cyc(5);
    chk("auto_pulses", 32'(pulse_total - p0), 32'd1);
`else
    n = 0;
    cyc(60);
    chk("noauto_pulses", 32'(pulse_total - p0), 32'd0);
    chk("noauto_state", 32'(db_estado), 32'd1);
`endif
    drive(8'h00, 8'h00, 1'b0);
    cyc(15);
    chk("hold_release", 32'(db_estado), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
